// File: rtl/led_palette_pkg.sv
// led_palette_pkg
//
// Shared definitions for the LED palette sequencer:
//   led_mode_t        per-LED runtime mode (OFF / SOLID / PULSE / BLINK), 2 bits
//   C_LED_VALUE_OFF   channel byte for a dark LED
//   C_LED_VALUE_FULL  channel byte for a fully lit LED
//   phase_init()      reset/resync value of a triangle generator
//   mode_value()      maps mode + generator state onto a channel byte
package led_palette_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_SOLID = 2'b01,
    LED_PULSE = 2'b10,
    LED_BLINK = 2'b11
  } led_mode_t;

  localparam logic [7:0] C_LED_VALUE_OFF  = 8'h00;
  localparam logic [7:0] C_LED_VALUE_FULL = 8'hFF;

  // Phase of generator k out of count generators of width p.
  // Spreads the generators evenly over the rising half of the triangle.
  // The value 0 is not a legal generator value, so the first LED starts at 1.
  function automatic int unsigned phase_init(input int unsigned k,
                                             input int unsigned count,
                                             input int unsigned p);
    int unsigned top;
    int unsigned v;
    top = (32'd1 << p) - 32'd1;
    v   = (k * top) / count;
    return (v < 32'd1) ? 32'd1 : v;
  endfunction

  // Channel byte for one LED before the colour mask is applied.
  // level is the already-expanded 8-bit pulse level, blink the generator b bit.
  function automatic logic [7:0] mode_value(input led_mode_t  mode,
                                            input logic [7:0] level,
                                            input logic       blink);
    logic [7:0] val;
    case (mode)
      LED_OFF:   val = C_LED_VALUE_OFF;
      LED_SOLID: val = C_LED_VALUE_FULL;
      LED_PULSE: val = level;
      LED_BLINK: val = blink ? C_LED_VALUE_FULL : C_LED_VALUE_OFF;
      default:   val = C_LED_VALUE_OFF;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/clock_enable_divider.sv
// clock_enable_divider
//
// Produces a one-cycle enable pulse every DIVISOR clock cycles.
// After reset the first pulse appears on the DIVISOR-th rising edge.
//
// Ports:
//   i_clk  in   system clock
//   i_rst  in   synchronous, active-high reset (restarts the count)
//   o_ce   out  enable, high for one cycle out of every DIVISOR
module clock_enable_divider #(
  parameter int unsigned DIVISOR = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_ce
);

  localparam int unsigned   CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // With DIVISOR = 1 the counter sits at 0 = LAST and the enable is constant.
  assign o_ce = (count == LAST);

endmodule

// File: rtl/led_triangle_gen.sv
// led_triangle_gen
//
// Free-running triangle generator for one LED. The value bounces between
// 1 and 2^P-1; at each turning point it dwells for one step while the
// direction flips, and the blink bit toggles, so b toggles twice per period
// of 2^(P+1)-2 steps.
//
// Ports:
//   i_clk     in   system clock
//   i_srst_n  in   synchronous, active-low reset (loads INIT_VALUE)
//   i_ce      in   step enable
//   i_pause   in   while high, step enables are discarded
//   i_resync  in   reloads INIT_VALUE, direction up, b cleared
//   o_v       out  current value, P bits, never 0
//   o_b       out  blink bit
module led_triangle_gen #(
  parameter int unsigned P          = 6,
  parameter int unsigned INIT_VALUE = 1
) (
  input  logic         i_clk,
  input  logic         i_srst_n,
  input  logic         i_ce,
  input  logic         i_pause,
  input  logic         i_resync,
  output logic [P-1:0] o_v,
  output logic         o_b
);

  localparam logic [P-1:0] V_MAX  = '1;
  localparam logic [P-1:0] V_MIN  = P'(1);
  localparam logic [P-1:0] V_INIT = P'(INIT_VALUE);

  logic dir_up;

  // Reset and resync load the same phase; a resync coinciding with a step
  // enable wins, so no step is taken on that edge.
  always_ff @(posedge i_clk) begin
    if (!i_srst_n || i_resync) begin
      o_v    <= V_INIT;
      dir_up <= 1'b1;
      o_b    <= 1'b0;
    end else if (i_ce && !i_pause) begin
      if (dir_up) begin
        if (o_v == V_MAX) begin
          dir_up <= 1'b0;
          o_b    <= ~o_b;
        end else begin
          o_v <= o_v + 1'b1;
        end
      end else begin
        if (o_v == V_MIN) begin
          dir_up <= 1'b1;
          o_b    <= ~o_b;
        end else begin
          o_v <= o_v - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_palette_sequencer.sv
// led_palette_sequencer
//
// Palette generator feeding the PWM LED driver. Every LED owns a
// phase-staggered triangle generator; its runtime mode selects off, solid,
// pulse (triangle level) or blink (triangle turning points). RGB LEDs also
// have a per-channel colour mask. All outputs are registered bytes.
//
// Parameters:
//   parm_color_led_count         N, number of RGB LEDs (>= 1)
//   parm_basic_led_count         M, number of single-colour LEDs (>= 1)
//   parm_FCLK                    i_clk frequency in Hz
//   parm_adjustments_per_second  generator step rate
//   parm_pulse_bits              triangle width P, 4..8
//
// Ports:
//   i_clk                    in   system clock
//   i_srst_n                 in   synchronous, active-low reset
//   i_pause                  in   freeze all generators while high
//   i_resync                 in   one-cycle pulse, reload all generator phases
//   i_color_mode             in   2N  mode of RGB LED k at [2k+1:2k]
//   i_color_mask             in   3N  {R,G,B} of RGB LED k at [3k+2:3k]
//   i_basic_mode             in   2M  mode of basic LED k at [2k+1:2k]
//   o_color_led_red_value    out  8N  LED k at [8k+7:8k]
//   o_color_led_green_value  out  8N  LED k at [8k+7:8k]
//   o_color_led_blue_value   out  8N  LED k at [8k+7:8k]
//   o_basic_led_lumin_value  out  8M  LED k at [8k+7:8k]
module led_palette_sequencer
  import led_palette_pkg::*;
#(
  parameter int unsigned parm_color_led_count        = 4,
  parameter int unsigned parm_basic_led_count        = 4,
  parameter int unsigned parm_FCLK                   = 40_000_000,
  parameter int unsigned parm_adjustments_per_second = 128,
  parameter int unsigned parm_pulse_bits             = 6
) (
  input  logic                              i_clk,
  input  logic                              i_srst_n,
  input  logic                              i_pause,
  input  logic                              i_resync,
  input  logic [2*parm_color_led_count-1:0] i_color_mode,
  input  logic [3*parm_color_led_count-1:0] i_color_mask,
  input  logic [2*parm_basic_led_count-1:0] i_basic_mode,
  output logic [8*parm_color_led_count-1:0] o_color_led_red_value,
  output logic [8*parm_color_led_count-1:0] o_color_led_green_value,
  output logic [8*parm_color_led_count-1:0] o_color_led_blue_value,
  output logic [8*parm_basic_led_count-1:0] o_basic_led_lumin_value
);

  localparam int unsigned N     = parm_color_led_count;
  localparam int unsigned M     = parm_basic_led_count;
  localparam int unsigned P     = parm_pulse_bits;
  localparam int unsigned D_RAW = parm_FCLK / parm_adjustments_per_second;
  localparam int unsigned D     = (D_RAW == 0) ? 1 : D_RAW;

  // The pulse level is v left-aligned in a byte with the spare low bits set,
  // so the top of the triangle reaches exactly 8'hFF.
  localparam int unsigned PAD      = 8 - P;
  localparam logic [7:0]  PAD_ONES = 8'((32'd1 << PAD) - 32'd1);

  function automatic logic [7:0] pulse_level(input logic [P-1:0] v);
    return (8'(v) << PAD) | PAD_ONES;
  endfunction

  // ---------------------------------------------------------------------
  // Step enable
  // ---------------------------------------------------------------------
  logic ce;

  clock_enable_divider #(
    .DIVISOR(D)
  ) u_ce_div (
    .i_clk(i_clk),
    .i_rst(!i_srst_n),
    .o_ce (ce)
  );

  // ---------------------------------------------------------------------
  // Generators, one per LED
  // ---------------------------------------------------------------------
  logic [P-1:0] color_v [N];
  logic [N-1:0] color_b;
  logic [P-1:0] basic_v [M];
  logic [M-1:0] basic_b;

  for (genvar g = 0; g < N; g++) begin : g_color_gen
    led_triangle_gen #(
      .P         (P),
      .INIT_VALUE(phase_init(g, N, P))
    ) u_gen (
      .i_clk   (i_clk),
      .i_srst_n(i_srst_n),
      .i_ce    (ce),
      .i_pause (i_pause),
      .i_resync(i_resync),
      .o_v     (color_v[g]),
      .o_b     (color_b[g])
    );
  end

  for (genvar g = 0; g < M; g++) begin : g_basic_gen
    led_triangle_gen #(
      .P         (P),
      .INIT_VALUE(phase_init(g, M, P))
    ) u_gen (
      .i_clk   (i_clk),
      .i_srst_n(i_srst_n),
      .i_ce    (ce),
      .i_pause (i_pause),
      .i_resync(i_resync),
      .o_v     (basic_v[g]),
      .o_b     (basic_b[g])
    );
  end

  // ---------------------------------------------------------------------
  // Value mapping. Modes and masks only steer the output path; the
  // generators keep running whatever the mode.
  // ---------------------------------------------------------------------
  logic [8*N-1:0] red_d;
  logic [8*N-1:0] green_d;
  logic [8*N-1:0] blue_d;
  logic [8*M-1:0] lumin_d;
  logic [7:0]     color_val;

  always_comb begin
    red_d     = '0;
    green_d   = '0;
    blue_d    = '0;
    lumin_d   = '0;
    color_val = C_LED_VALUE_OFF;
    for (int k = 0; k < N; k++) begin
      color_val = mode_value(led_mode_t'(i_color_mode[2*k +: 2]),
                             pulse_level(color_v[k]), color_b[k]);
      red_d[8*k +: 8]   = i_color_mask[3*k+2] ? color_val : C_LED_VALUE_OFF;
      green_d[8*k +: 8] = i_color_mask[3*k+1] ? color_val : C_LED_VALUE_OFF;
      blue_d[8*k +: 8]  = i_color_mask[3*k]   ? color_val : C_LED_VALUE_OFF;
    end
    for (int k = 0; k < M; k++) begin
      lumin_d[8*k +: 8] = mode_value(led_mode_t'(i_basic_mode[2*k +: 2]),
                                     pulse_level(basic_v[k]), basic_b[k]);
    end
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      o_color_led_red_value   <= '0;
      o_color_led_green_value <= '0;
      o_color_led_blue_value  <= '0;
      o_basic_led_lumin_value <= '0;
    end else begin
      o_color_led_red_value   <= red_d;
      o_color_led_green_value <= green_d;
      o_color_led_blue_value  <= blue_d;
      o_basic_led_lumin_value <= lumin_d;
    end
  end

endmodule

// File: tb/tb_led_palette_sequencer.sv
// tb_led_palette_sequencer
//
// Bench for led_palette_sequencer with N = M = 4, P = 6 and a step divisor
// of 4. A behavioural model derives every LED's triangle position directly
// from the number of steps taken since the last reload, and a compare
// process checks all four output vectors against it on every falling edge.
// Directed literal checks pin reset, phases, triangle turns, masks, blink,
// pause/resync and mid-run reset.
module tb_led_palette_sequencer;

  localparam int N    = 4;
  localparam int M    = 4;
  localparam int P    = 6;
  localparam int D    = 4;
  localparam int RATE = 128;
  localparam int FCLK = D * RATE;
  localparam int HALF = (1 << P) - 1;

  // ---------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------
  logic           clk;
  logic           srst_n;
  logic           pause;
  logic           resync;
  logic [2*N-1:0] color_mode;
  logic [3*N-1:0] color_mask;
  logic [2*M-1:0] basic_mode;
  logic [8*N-1:0] red;
  logic [8*N-1:0] green;
  logic [8*N-1:0] blue;
  logic [8*M-1:0] lumin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_palette_sequencer #(
    .parm_color_led_count       (N),
    .parm_basic_led_count       (M),
    .parm_FCLK                  (FCLK),
    .parm_adjustments_per_second(RATE),
    .parm_pulse_bits            (P)
  ) dut (
    .i_clk                  (clk),
    .i_srst_n               (srst_n),
    .i_pause                (pause),
    .i_resync               (resync),
    .i_color_mode           (color_mode),
    .i_color_mask           (color_mask),
    .i_basic_mode           (basic_mode),
    .o_color_led_red_value  (red),
    .o_color_led_green_value(green),
    .o_color_led_blue_value (blue),
    .o_basic_led_lumin_value(lumin)
  );

  // ---------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // A generator that started at v0 going up, after s steps, sits at
  // position (v0-1+s) mod 2*HALF of its period; the first HALF positions
  // rise 1..HALF, the rest fall HALF..1. b flips each time the position
  // passes a multiple of HALF.
  // ---------------------------------------------------------------------
  int               steps     = 0;  // steps since last reset/resync
  int               since_rel = 0;  // rising edges since reset release
  logic [127:0]     exp_q[$];

  function automatic int phase(input int k, input int count);
    int v;
    v = (k * HALF) / count;
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int gen_v(input int v0, input int s);
    int pos;
    pos = (v0 - 1 + s) % (2 * HALF);
    return (pos < HALF) ? pos + 1 : 2 * HALF - pos;
  endfunction

  function automatic bit gen_b(input int v0, input int s);
    return (((v0 - 1 + s) / HALF) % 2) == 1;
  endfunction

  function automatic logic [7:0] led_value(input logic [1:0] mode, input int v0, input int s);
    logic [7:0] val;
    case (mode)
      2'b00:   val = 8'h00;
      2'b01:   val = 8'hFF;
      2'b10:   val = 8'(gen_v(v0, s) * (1 << (8 - P)) + (1 << (8 - P)) - 1);
      default: val = gen_b(v0, s) ? 8'hFF : 8'h00;
    endcase
    return val;
  endfunction

  always @(posedge clk) begin
    logic [31:0] r, g, bl, l;
    logic [7:0]  val;
    r = '0; g = '0; bl = '0; l = '0;
    if (!srst_n) begin
      steps     = 0;
      since_rel = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        val = led_value(color_mode[2*k +: 2], phase(k, N), steps);
        r[8*k +: 8]  = color_mask[3*k+2] ? val : 8'h00;
        g[8*k +: 8]  = color_mask[3*k+1] ? val : 8'h00;
        bl[8*k +: 8] = color_mask[3*k]   ? val : 8'h00;
      end
      for (int k = 0; k < M; k++) begin
        l[8*k +: 8] = led_value(basic_mode[2*k +: 2], phase(k, M), steps);
      end
      since_rel++;
      if (resync) steps = 0;
      else if ((since_rel % D) == 0 && !pause) steps++;
    end
    exp_q.push_back({r, g, bl, l});
  end

  // Scoreboard: one expected entry per rising edge, compared mid-cycle.
  always @(negedge clk) begin
    logic [127:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model_red",   red,   e[127:96]);
      check("model_green", green, e[95:64]);
      check("model_blue",  blue,  e[63:32]);
      check("model_lumin", lumin, e[31:0]);
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the falling edge just before a step-enable edge.
  task automatic align_to_ce();
    int guard;
    guard = 0;
    while (((since_rel + 1) % D) != 0 && guard < 2 * D) begin
      @(negedge clk);
      guard++;
    end
    check("align_to_ce_bound", 32'(guard < 2 * D), 32'd1);
  endtask

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    srst_n     = 1'b0;
    pause      = 1'b0;
    resync     = 1'b0;
    color_mode = 8'hAA;   // all PULSE
    color_mask = 12'hFFF; // all channels on
    basic_mode = 8'hE1;   // LED0 SOLID, LED1 OFF, LED2 PULSE, LED3 BLINK

    // Reset and phases
    cycles(3);
    check("reset_red",   red,   32'h0);
    check("reset_lumin", lumin, 32'h0);
    srst_n = 1'b1;
    cycles(1);                                  // edge 1 after release
    check("phase_red",   red,   32'hBF7F3F07);
    check("phase_blue",  blue,  32'hBF7F3F07);
    check("phase_lumin", lumin, 32'h007F00FF);

    // Triangle wrap on LED0 (steps land on every 4th edge)
    cycles(248);                                // edge 249: 62 steps, v = 63
    check("wrap_top",       32'(red[7:0]), 32'hFF);
    cycles(4);                                  // edge 253: turning dwell
    check("wrap_top_hold",  32'(red[7:0]), 32'hFF);
    cycles(4);                                  // edge 257: v = 62
    check("wrap_fall",      32'(red[7:0]), 32'hFB);
    cycles(244);                                // edge 501: v = 1
    check("wrap_bottom",    32'(red[7:0]), 32'h07);
    cycles(4);                                  // edge 505: bottom dwell
    check("wrap_bot_hold",  32'(red[7:0]), 32'h07);
    cycles(4);                                  // edge 509: v = 2
    check("wrap_rise",      32'(red[7:0]), 32'h0B);

    // Masks and modes on LED1
    color_mode[3:2] = 2'b01;
    color_mask[5:3] = 3'b101;
    cycles(1);
    check("mask_red",   32'(red[15:8]),   32'hFF);
    check("mask_green", 32'(green[15:8]), 32'h00);
    check("mask_blue",  32'(blue[15:8]),  32'hFF);
    color_mode[3:2] = 2'b00;
    cycles(1);
    check("off_red",   32'(red[15:8]),   32'h00);
    check("off_blue",  32'(blue[15:8]),  32'h00);
    color_mode[3:2] = 2'b10;
    color_mask[5:3] = 3'b111;

    // Pause across three step enables, then resync on a step edge
    pause = 1'b1;
    cycles(12);
    pause = 1'b0;
    cycles(3);
    align_to_ce();
    resync = 1'b1;
    cycles(1);                                  // resync edge R
    resync = 1'b0;
    cycles(1);                                  // edge R+1
    check("resync_led0", 32'(red[7:0]), 32'h07);
    check("resync_red",  red,   32'hBF7F3F07);
    check("resync_lumin", lumin, 32'h007F00FF);

    // BLINK on LED0 toggles at each turn of its triangle
    color_mode[1:0] = 2'b11;
    cycles(1);                                  // edge R+2
    check("blink_start", 32'(red[7:0]), 32'h00);
    cycles(250);                                // edge R+252
    check("blink_pre_top", 32'(red[7:0]), 32'h00);
    cycles(1);                                  // edge R+253
    check("blink_top",     32'(red[7:0]), 32'hFF);
    cycles(251);                                // edge R+504
    check("blink_pre_bot", 32'(red[7:0]), 32'hFF);
    cycles(1);                                  // edge R+505
    check("blink_bot",     32'(red[7:0]), 32'h00);
    color_mode = 8'hAA;

    // Mid-run reset for a single cycle
    cycles(30);
    srst_n = 1'b0;
    cycles(1);
    check("midrst_red",   red,   32'h0);
    check("midrst_green", green, 32'h0);
    check("midrst_blue",  blue,  32'h0);
    check("midrst_lumin", lumin, 32'h0);
    srst_n = 1'b1;
    cycles(1);
    check("midrst_phase_red",   red,   32'hBF7F3F07);
    check("midrst_phase_lumin", lumin, 32'h007F00FF);
    cycles(100);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
